// File: rtl/cpu_pkg.sv
// Shared opcodes, widths and execute-stage operation encoding for the
// three-stage fetch/decode/execute core.
package cpu_pkg;

    localparam int unsigned REG_W  = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_MOV  = 8'h02;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_NOP  = 8'h0f;
    localparam logic [7:0] OP_AND  = 8'h26;
    localparam logic [7:0] OP_LSHR = 8'h27;
    localparam logic [7:0] OP_ASHL = 8'h28;
    localparam logic [7:0] OP_SUB  = 8'h29;
    localparam logic [7:0] OP_NEG  = 8'h2a;
    localparam logic [7:0] OP_OR   = 8'h2b;
    localparam logic [7:0] OP_NOT  = 8'h2c;
    localparam logic [7:0] OP_ASHR = 8'h2d;
    localparam logic [7:0] OP_XOR  = 8'h2e;
    localparam logic [7:0] OP_MUL  = 8'h2f;

    typedef enum logic [5:0] {
        DX_NOP, DX_LDI, DX_MOV, DX_ADD, DX_AND, DX_LSHR, DX_ASHL,
        DX_SUB, DX_NEG, DX_OR, DX_NOT, DX_ASHR, DX_XOR, DX_MUL
    } dx_op_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational execute-stage ALU; all arithmetic wraps at 32 bits.
module cpu_alu
    import cpu_pkg::*;
(
    input  dx_op_t              op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [DATA_W-1:0]   imm,
    output logic [DATA_W-1:0]   result
);

    always_comb begin
        result = '0;
        unique case (op)
            DX_LDI:  result = imm;
            DX_MOV:  result = b;
            DX_ADD:  result = a + b;
            DX_AND:  result = a & b;
            DX_LSHR: result = a >> b[4:0];
            DX_ASHL: result = a << b[4:0];
            DX_SUB:  result = a - b;
            DX_NEG:  result = -b;
            DX_OR:   result = a | b;
            DX_NOT:  result = ~b;
            DX_ASHR: result = $signed(a) >>> b[4:0];
            DX_XOR:  result = a ^ b;
            DX_MUL:  result = a * b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/cpu_fetch_decode_execute.sv
// Three-stage in-order Moxie integer core with RAW hazard stalling against
// an external, registered-read, non-write-through register file.
module cpu_fetch_decode_execute
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    input  logic [47:0] imem_data_i,
    output logic        rf_re_o,
    output logic [3:0]  rf_idx1_o,
    output logic [3:0]  rf_idx2_o,
    input  logic [31:0] rf_val1_i,
    input  logic [31:0] rf_val2_i,
    output logic        rf_we_o,
    output logic [3:0]  rf_widx_o,
    output logic [31:0] rf_wdata_o,
    output logic        stall_o,
    output logic        illegal_o
);

    logic [31:0]       pc;
    logic              fd_valid;
    logic [15:0]       fd_opcode;
    logic [31:0]       fd_operand;

    dx_op_t            dx_op;
    logic              dx_we;
    logic [REG_W-1:0]  dx_widx;
    logic [DATA_W-1:0] dx_imm;

    dx_op_t            dec_op;
    logic              use1;
    logic              use2;
    logic              legal;
    logic [REG_W-1:0]  idx_a;
    logic [REG_W-1:0]  idx_b;
    logic              hit_a;
    logic              hit_b;
    logic              stall;
    logic              long_insn;
    logic [DATA_W-1:0] alu_result;

    assign idx_a       = fd_opcode[7:4];
    assign idx_b       = fd_opcode[3:0];
    assign long_insn   = (imem_data_i[47:40] == OP_LDI);
    assign imem_addr_o = pc;
    assign rf_idx1_o   = idx_a;
    assign rf_idx2_o   = idx_b;
    assign rf_re_o     = fd_valid & (use1 | use2);

    always_comb begin
        dec_op = DX_NOP;
        use1   = 1'b0;
        use2   = 1'b0;
        legal  = 1'b1;
        case (fd_opcode[15:8])
            OP_LDI:  dec_op = DX_LDI;
            OP_MOV:  begin dec_op = DX_MOV;  use2 = 1'b1; end
            OP_ADD:  begin dec_op = DX_ADD;  use1 = 1'b1; use2 = 1'b1; end
            OP_NOP:  dec_op = DX_NOP;
            OP_AND:  begin dec_op = DX_AND;  use1 = 1'b1; use2 = 1'b1; end
            OP_LSHR: begin dec_op = DX_LSHR; use1 = 1'b1; use2 = 1'b1; end
            OP_ASHL: begin dec_op = DX_ASHL; use1 = 1'b1; use2 = 1'b1; end
            OP_SUB:  begin dec_op = DX_SUB;  use1 = 1'b1; use2 = 1'b1; end
            OP_NEG:  begin dec_op = DX_NEG;  use2 = 1'b1; end
            OP_OR:   begin dec_op = DX_OR;   use1 = 1'b1; use2 = 1'b1; end
            OP_NOT:  begin dec_op = DX_NOT;  use2 = 1'b1; end
            OP_ASHR: begin dec_op = DX_ASHR; use1 = 1'b1; use2 = 1'b1; end
            OP_XOR:  begin dec_op = DX_XOR;  use1 = 1'b1; use2 = 1'b1; end
            OP_MUL:  begin dec_op = DX_MUL;  use1 = 1'b1; use2 = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

    // Both the D/X slot and the execute output are still unwritten when the
    // read is issued, since the register file does not forward writes.
    assign hit_a   = (dx_we & (dx_widx == idx_a)) | (rf_we_o & (rf_widx_o == idx_a));
    assign hit_b   = (dx_we & (dx_widx == idx_b)) | (rf_we_o & (rf_widx_o == idx_b));
    assign stall   = fd_valid & ((use1 & hit_a) | (use2 & hit_b));
    assign stall_o = stall;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc         <= RESET_PC;
            fd_valid   <= 1'b0;
            fd_opcode  <= '0;
            fd_operand <= '0;
        end else if (!stall) begin
            pc         <= pc + (long_insn ? 32'd6 : 32'd2);
            fd_valid   <= 1'b1;
            fd_opcode  <= imem_data_i[47:32];
            fd_operand <= long_insn ? imem_data_i[31:0] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dx_op     <= DX_NOP;
            dx_we     <= 1'b0;
            dx_widx   <= '0;
            dx_imm    <= '0;
            illegal_o <= 1'b0;
        end else if (stall || !fd_valid) begin
            dx_op     <= DX_NOP;
            dx_we     <= 1'b0;
            dx_widx   <= '0;
            dx_imm    <= '0;
            illegal_o <= 1'b0;
        end else begin
            dx_op     <= dec_op;
            dx_we     <= (dec_op != DX_NOP);
            dx_widx   <= idx_a;
            dx_imm    <= fd_operand;
            illegal_o <= ~legal;
        end
    end

    cpu_alu u_alu (
        .op     (dx_op),
        .a      (rf_val1_i),
        .b      (rf_val2_i),
        .imm    (dx_imm),
        .result (alu_result)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rf_we_o    <= 1'b0;
            rf_widx_o  <= '0;
            rf_wdata_o <= '0;
        end else begin
            rf_we_o    <= dx_we;
            rf_widx_o  <= dx_widx;
            rf_wdata_o <= alu_result;
        end
    end

endmodule

// File: tb/tb_cpu_fetch_decode_execute.sv
// Directed bench: instruction memory and register-file models around the core,
// with hand-computed expected write sequences.
module tb_cpu_fetch_decode_execute;

    localparam logic [31:0] RESET_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] imem_addr;
    logic [47:0] imem_data;
    logic        rf_re;
    logic [3:0]  rf_idx1;
    logic [3:0]  rf_idx2;
    logic [31:0] rf_val1;
    logic [31:0] rf_val2;
    logic        rf_we;
    logic [3:0]  rf_widx;
    logic [31:0] rf_wdata;
    logic        stall;
    logic        illegal;

    always #5 clk = ~clk;

    cpu_fetch_decode_execute #(.RESET_PC(RESET_PC)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .imem_addr_o (imem_addr),
        .imem_data_i (imem_data),
        .rf_re_o     (rf_re),
        .rf_idx1_o   (rf_idx1),
        .rf_idx2_o   (rf_idx2),
        .rf_val1_i   (rf_val1),
        .rf_val2_i   (rf_val2),
        .rf_we_o     (rf_we),
        .rf_widx_o   (rf_widx),
        .rf_wdata_o  (rf_wdata),
        .stall_o     (stall),
        .illegal_o   (illegal)
    );

    logic [15:0] mem [0:255];
    logic [7:0]  fidx;
    assign fidx      = imem_addr[8:1];
    assign imem_data = {mem[fidx], mem[fidx + 8'd1], mem[fidx + 8'd2]};

    // Registered reads, no write-through: a same-edge write is not visible.
    logic [31:0] regs [0:15];
    always @(posedge clk) begin
        if (rf_re) begin
            rf_val1 <= regs[rf_idx1];
            rf_val2 <= regs[rf_idx2];
        end
        if (rf_we) regs[rf_widx] <= rf_wdata;
    end

    int tests_run = 0;
    int tests_failed = 0;
    int stall_cnt;
    int illegal_cnt;
    logic [15:0] prog [$];
    logic [3:0]  wlog_idx [$];
    logic [31:0] wlog_dat [$];
    logic [3:0]  e_idx [$];
    logic [31:0] e_dat [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start();
        @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0f00;
        for (int i = 0; i < prog.size(); i++) mem[8'(32 + i)] = prog[i];
        #1;
        stall_cnt   = 0;
        illegal_cnt = 0;
        wlog_idx.delete();
        wlog_dat.delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (stall)   stall_cnt++;
            if (illegal) illegal_cnt++;
            if (rf_we) begin
                wlog_idx.push_back(rf_widx);
                wlog_dat.push_back(rf_wdata);
            end
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_nwrites"}, 32'(wlog_idx.size()), 32'(e_idx.size()));
        for (int i = 0; i < e_idx.size() && i < wlog_idx.size(); i++) begin
            check($sformatf("%s_idx%0d", tag, i), 32'(wlog_idx[i]), 32'(e_idx[i]));
            check($sformatf("%s_dat%0d", tag, i), wlog_dat[i], e_dat[i]);
        end
    endtask

    initial begin
        // Reset state, then a single long ldi.l through the pipe
        prog = '{16'h0110, 16'h1234, 16'h5678};
        start();
        check("rst_addr",    imem_addr, RESET_PC);
        check("rst_we",      32'(rf_we), 32'd0);
        check("rst_stall",   32'(stall), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_re",      32'(rf_re), 32'd0);
        release_reset();
        check("rel_addr", imem_addr, RESET_PC);
        run(1);
        check("ldi_pc6",  imem_addr, RESET_PC + 32'd6);
        check("ldi_re",   32'(rf_re), 32'd0);
        run(1);
        check("nop_pc2",  imem_addr, RESET_PC + 32'd8);
        check("ldi_we_e2", 32'(rf_we), 32'd0);
        run(1);
        check("ldi_we",    32'(rf_we), 32'd1);
        check("ldi_widx",  32'(rf_widx), 32'd1);
        check("ldi_wdata", rf_wdata, 32'h1234_5678);

        // RAW hazard: add.l $r2,$r3 after two ldi.l
        prog = '{16'h0120, 16'h0000, 16'h0005, 16'h0130, 16'h0000, 16'h0007, 16'h0523};
        start();
        release_reset();
        run(12);
        check("haz_stalls", 32'(stall_cnt), 32'd2);
        e_idx = '{4'd2, 4'd3, 4'd2};
        e_dat = '{32'd5, 32'd7, 32'd12};
        check_log("haz");

        // ALU corner cases
        prog = '{16'h0140, 16'h8000, 16'h0000, 16'h0150, 16'h0000, 16'h0004,
                 16'h0160, 16'h8000, 16'h0000, 16'h2d45, 16'h2765,
                 16'h0170, 16'h0001, 16'h0000, 16'h0180, 16'h0001, 16'h0000, 16'h2f78,
                 16'h0190, 16'h0000, 16'h0003, 16'h01a0, 16'h0000, 16'h0005, 16'h299a};
        start();
        release_reset();
        run(40);
        e_idx = '{4'd4, 4'd5, 4'd6, 4'd4, 4'd6, 4'd7, 4'd8, 4'd7, 4'd9, 4'd10, 4'd9};
        e_dat = '{32'h8000_0000, 32'd4, 32'h8000_0000, 32'hF800_0000, 32'h0800_0000,
                  32'h0001_0000, 32'h0001_0000, 32'h0, 32'd3, 32'd5, 32'hFFFF_FFFE};
        check_log("alu");

        // Unsupported opcode
        prog = '{16'h3f00};
        start();
        release_reset();
        run(1);
        check("ill_pc2",   imem_addr, RESET_PC + 32'd2);
        check("ill_early", 32'(illegal), 32'd0);
        run(1);
        check("ill_pulse", 32'(illegal), 32'd1);
        run(1);
        check("ill_clear", 32'(illegal), 32'd0);
        run(5);
        check("ill_count",  32'(illegal_cnt), 32'd1);
        check("ill_writes", 32'(wlog_idx.size()), 32'd0);

        // Asynchronous reset mid-stream
        prog = '{16'h0120, 16'h0000, 16'h0005, 16'h0130, 16'h0000, 16'h0007, 16'h0523};
        start();
        release_reset();
        run(3);
        check("pre_we",    32'(rf_we), 32'd1);
        check("pre_stall", 32'(stall), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check("async_we",    32'(rf_we), 32'd0);
        check("async_stall", 32'(stall), 32'd0);
        check("async_addr",  imem_addr, RESET_PC);
        check("async_wdata", rf_wdata, 32'd0);
        check("async_re",    32'(rf_re), 32'd0);
        stall_cnt = 0;
        wlog_idx.delete();
        wlog_dat.delete();
        release_reset();
        run(1);
        check("restart_pc", imem_addr, RESET_PC + 32'd6);
        run(11);
        check("restart_stalls", 32'(stall_cnt), 32'd2);
        e_idx = '{4'd2, 4'd3, 4'd2};
        e_dat = '{32'd5, 32'd7, 32'd12};
        check_log("restart");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
